// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between decode/execute and CP0.
// Accepts syscall/break/teq/irq/eret and drives a fixed two-cycle CP0 strobe + PC redirect sequence.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
    parameter logic [2:0]  MAX_DEPTH  = 3'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] pc,
    input  logic        is_syscall,
    input  logic        is_break,
    input  logic        is_teq,
    input  logic        is_eret,
    input  logic        teq_eq,
    input  logic        irq,
    input  logic [31:0] status,
    input  logic [31:0] epc,
    output logic        stall,
    output logic        exception,
    output logic [4:0]  cause,
    output logic [31:0] exc_pc,
    output logic        eret,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [2:0]  depth,
    output logic        irq_pending
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TAKE = 3'd1,
        S_VEC  = 3'd2,
        S_RET  = 3'd3,
        S_RVEC = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_stall;
    logic        r_irq_s1, r_irq_s2, r_irq_d;
    logic        r_irq_pending;
    logic [2:0]  r_depth;
    logic        r_exception, r_eret, r_redirect;
    logic [4:0]  r_cause;
    logic [31:0] r_exc_pc, r_redirect_pc;
    logic        w_idle, w_depth_ok, w_sync_req;
    logic        w_eret_acc, w_sync_acc, w_irq_acc, w_exc_acc, w_irq_rise;
    logic [4:0]  w_cause;

    assign w_idle     = (r_state == S_IDLE);
    assign w_depth_ok = (r_depth < MAX_DEPTH);
    assign w_sync_req = (is_syscall & status[1]) | (is_break & status[2])
                      | (is_teq & teq_eq & status[3]);
    assign w_eret_acc = w_idle & inst_valid & is_eret & (r_depth != 3'd0);
    assign w_sync_acc = w_idle & inst_valid & ~is_eret & status[0] & w_depth_ok & w_sync_req;
    // An interrupt only rides on an instruction that is neither an accepted eret nor a taken trap.
    assign w_irq_acc  = w_idle & inst_valid & ~w_eret_acc & ~w_sync_acc & r_irq_pending
                      & status[0] & status[4] & w_depth_ok;
    assign w_exc_acc  = w_sync_acc | w_irq_acc;
    assign w_irq_rise = r_irq_s2 & ~r_irq_d;

    // Cause code of the accepted request; interrupts use code 0.
    always_comb begin
        w_cause = 5'd0;
        if (w_sync_acc & is_syscall) begin
            w_cause = 5'd8;
        end else if (w_sync_acc & is_break) begin
            w_cause = 5'd9;
        end else if (w_sync_acc & is_teq) begin
            w_cause = 5'd13;
        end else begin
            w_cause = 5'd0;
        end
    end

    // Interrupt synchronizer and edge-detect stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_s1 <= 1'b0;
            r_irq_s2 <= 1'b0;
            r_irq_d  <= 1'b0;
        end else begin
            r_irq_s1 <= irq;
            r_irq_s2 <= r_irq_s1;
            r_irq_d  <= r_irq_s2;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and the combinational stall.
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_eret_acc) begin
                    w_next  = S_RET;
                    w_stall = 1'b1;
                end else if (w_exc_acc) begin
                    w_next  = S_TAKE;
                    w_stall = 1'b1;
                end else begin
                    w_next  = S_IDLE;
                end
            end
            S_TAKE: begin
                w_next  = S_VEC;
                w_stall = 1'b1;
            end
            S_VEC:  w_next = S_IDLE;
            S_RET: begin
                w_next  = S_RVEC;
                w_stall = 1'b1;
            end
            S_RVEC: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered strobes, captured cause/pc and redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exception   <= 1'b0;
            r_eret        <= 1'b0;
            r_redirect    <= 1'b0;
            r_cause       <= 5'd0;
            r_exc_pc      <= 32'd0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_exception <= (w_next == S_TAKE);
            r_eret      <= (w_next == S_RET);
            r_redirect  <= (w_next == S_VEC) | (w_next == S_RVEC);
            if (w_exc_acc) begin
                r_cause  <= w_cause;
                r_exc_pc <= pc;
            end
            if (w_next == S_VEC) begin
                r_redirect_pc <= EXC_VECTOR;
            end else if (w_next == S_RVEC) begin
                r_redirect_pc <= epc;
            end
        end
    end

    // Nesting depth and pending-interrupt latch; a new rising edge beats a same-cycle take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_depth       <= 3'd0;
            r_irq_pending <= 1'b0;
        end else begin
            if ((r_state == S_TAKE) && (r_depth < MAX_DEPTH)) begin
                r_depth <= r_depth + 3'd1;
            end else if ((r_state == S_RET) && (r_depth != 3'd0)) begin
                r_depth <= r_depth - 3'd1;
            end
            if (w_irq_rise) begin
                r_irq_pending <= 1'b1;
            end else if (w_irq_acc) begin
                r_irq_pending <= 1'b0;
            end
        end
    end

    assign stall       = w_stall & ~rst;
    assign exception   = r_exception;
    assign eret        = r_eret;
    assign redirect    = r_redirect;
    assign cause       = r_cause;
    assign exc_pc      = r_exc_pc;
    assign redirect_pc = r_redirect_pc;
    assign depth       = r_depth;
    assign irq_pending = r_irq_pending;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed vectors push expected CP0/redirect events,
// a negedge monitor pops and compares them whenever a strobe appears.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst, inst_valid, is_syscall, is_break, is_teq, is_eret, teq_eq, irq;
    logic [31:0] pc, status, epc;
    logic        stall, exception, eret, redirect, irq_pending;
    logic [4:0]  cause;
    logic [31:0] exc_pc, redirect_pc;
    logic [2:0]  depth;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc),
        .is_syscall(is_syscall), .is_break(is_break), .is_teq(is_teq), .is_eret(is_eret),
        .teq_eq(teq_eq), .irq(irq), .status(status), .epc(epc),
        .stall(stall), .exception(exception), .cause(cause), .exc_pc(exc_pc),
        .eret(eret), .redirect(redirect), .redirect_pc(redirect_pc),
        .depth(depth), .irq_pending(irq_pending)
    );

    localparam logic [1:0]  K_EXC  = 2'd0;
    localparam logic [1:0]  K_ERET = 2'd1;
    localparam logic [1:0]  K_RED  = 2'd2;
    localparam logic [31:0] VEC    = 32'h0040_0004;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  cause;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic push_exc(input logic [4:0] c, input logic [31:0] p);
        sb_q.push_back('{K_EXC, c, p});
        sb_q.push_back('{K_RED, 5'd0, VEC});
    endtask

    task automatic push_ret(input logic [31:0] target);
        sb_q.push_back('{K_ERET, 5'd0, 32'd0});
        sb_q.push_back('{K_RED, 5'd0, target});
    endtask

    // kind: 0 plain, 1 syscall, 2 break, 3 teq, 4 eret. Called and returns at posedge+1.
    task automatic issue(input logic [31:0] ipc, input int kind, input logic teq_e,
                         input logic exp_stall, input string name);
        pc = ipc; inst_valid = 1'b1; teq_eq = teq_e;
        is_syscall = (kind == 1); is_break = (kind == 2);
        is_teq = (kind == 3); is_eret = (kind == 4);
        #1 check({name, "_stall"}, {31'd0, stall}, {31'd0, exp_stall});
        @(posedge clk); #1;
        inst_valid = 1'b0; is_syscall = 1'b0; is_break = 1'b0;
        is_teq = 1'b0; is_eret = 1'b0; teq_eq = 1'b0;
        check({name, "_stall_seq"}, {31'd0, stall}, {31'd0, exp_stall});
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_depth(input string name, input logic [2:0] d);
        check({name, "_depth"}, {29'd0, depth}, {29'd0, d});
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [1:0] k;
        if (!rst && (exception || eret || redirect)) begin
            check("strobe_overlap", {31'd0, (exception & eret) | (redirect & (exception | eret))}, 32'd0);
            k = exception ? K_EXC : (eret ? K_ERET : K_RED);
            if (sb_q.size() == 0) begin
                check("unexpected_event", {30'd0, k}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("event_kind", {30'd0, k}, {30'd0, e.kind});
                if (k == K_EXC) begin
                    check("cause", {27'd0, cause}, {27'd0, e.cause});
                    check("exc_pc", exc_pc, e.val);
                end else if (k == K_RED) begin
                    check("redirect_pc", redirect_pc, e.val);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; inst_valid = 1'b0; pc = 32'd0; is_syscall = 1'b0; is_break = 1'b0;
        is_teq = 1'b0; is_eret = 1'b0; teq_eq = 1'b0; irq = 1'b0; status = 32'd0; epc = 32'd0;
        #2;
        check("rst_exception", {31'd0, exception}, 32'd0);
        check("rst_eret", {31'd0, eret}, 32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_cause", {27'd0, cause}, 32'd0);
        check("rst_exc_pc", exc_pc, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_depth", {29'd0, depth}, 32'd0);
        check("rst_irq_pending", {31'd0, irq_pending}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; status = 32'h1F;

        push_exc(5'd8, 32'h0040_0100);
        issue(32'h0040_0100, 1, 1'b0, 1'b1, "sys1");
        drain("sys1"); chk_depth("sys1", 3'd1);

        epc = 32'h0040_0104; push_ret(32'h0040_0104);
        issue(32'h0040_0104, 4, 1'b0, 1'b1, "eret1");
        drain("eret1"); chk_depth("eret1", 3'd0);

        status = 32'h1D;
        issue(32'h0040_0110, 1, 1'b0, 1'b0, "sys_masked");
        idle(3); chk_depth("sys_masked", 3'd0);
        status = 32'h1F;

        issue(32'h0040_0120, 3, 1'b0, 1'b0, "teq_false");
        idle(3);
        push_exc(5'd13, 32'h0040_0124);
        issue(32'h0040_0124, 3, 1'b1, 1'b1, "teq_true");
        drain("teq_true"); chk_depth("teq_true", 3'd1);
        epc = 32'h0040_0128; push_ret(32'h0040_0128);
        issue(32'h0040_0128, 4, 1'b0, 1'b1, "eret_teq");
        drain("eret_teq");

        issue(32'h0040_0130, 4, 1'b0, 1'b0, "eret_depth0");
        idle(3); chk_depth("eret_depth0", 3'd0);

        status = 32'h0F; irq = 1'b1; idle(3); irq = 1'b0; idle(3);
        check("irq_masked_pending", {31'd0, irq_pending}, 32'd1);
        issue(32'h0040_0200, 0, 1'b0, 1'b0, "plain_masked");
        idle(2);
        check("irq_still_pending", {31'd0, irq_pending}, 32'd1);
        status = 32'h1F;
        push_exc(5'd0, 32'h0040_0204);
        issue(32'h0040_0204, 0, 1'b0, 1'b1, "irq_take");
        drain("irq_take");
        check("irq_cleared", {31'd0, irq_pending}, 32'd0);
        chk_depth("irq_take", 3'd1);
        epc = 32'h0040_0204; push_ret(32'h0040_0204);
        issue(32'h0040_0204, 4, 1'b0, 1'b1, "eret_irq");
        drain("eret_irq");

        irq = 1'b1; idle(3); irq = 1'b0; idle(3);
        check("brk_irq_pending", {31'd0, irq_pending}, 32'd1);
        push_exc(5'd9, 32'h0040_0300);
        issue(32'h0040_0300, 2, 1'b0, 1'b1, "brk_vs_irq");
        drain("brk_vs_irq");
        check("irq_lost_prio", {31'd0, irq_pending}, 32'd1);
        epc = 32'h0040_0300; push_ret(32'h0040_0300);
        issue(32'h0040_0300, 4, 1'b0, 1'b1, "eret_vs_irq");
        drain("eret_vs_irq");
        check("irq_after_eret", {31'd0, irq_pending}, 32'd1);
        chk_depth("eret_vs_irq", 3'd0);
        push_exc(5'd0, 32'h0040_0304);
        issue(32'h0040_0304, 0, 1'b0, 1'b1, "irq_after_brk");
        drain("irq_after_brk");
        check("irq_cleared2", {31'd0, irq_pending}, 32'd0);
        epc = 32'h0040_0304; push_ret(32'h0040_0304);
        issue(32'h0040_0304, 4, 1'b0, 1'b1, "eret_irq2");
        drain("eret_irq2");

        for (int i = 0; i < 6; i++) begin
            push_exc(5'd8, 32'h0040_0400 + 32'(4 * i));
            issue(32'h0040_0400 + 32'(4 * i), 1, 1'b0, 1'b1, "nest");
            drain("nest");
            chk_depth("nest", 3'(i + 1));
        end
        issue(32'h0040_0500, 1, 1'b0, 1'b0, "sys_depth_max");
        idle(3); chk_depth("sys_depth_max", 3'd6);
        epc = 32'h0040_0414; push_ret(32'h0040_0414);
        issue(32'h0040_0414, 4, 1'b0, 1'b1, "eret_from6");
        drain("eret_from6"); chk_depth("eret_from6", 3'd5);

        issue(32'h0040_0600, 1, 1'b0, 1'b1, "sys_then_rst");
        check("take_exception_hi", {31'd0, exception}, 32'd1);
        rst = 1'b1; #1;
        check("mid_rst_exception", {31'd0, exception}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_cause", {27'd0, cause}, 32'd0);
        check("mid_rst_exc_pc", exc_pc, 32'd0);
        check("mid_rst_redirect", {31'd0, redirect}, 32'd0);
        check("mid_rst_redirect_pc", redirect_pc, 32'd0);
        check("mid_rst_depth", {29'd0, depth}, 32'd0);
        idle(1); rst = 1'b0;
        idle(3);
        check("post_rst_redirect", {31'd0, redirect}, 32'd0);
        check("post_rst_queue", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt sequencer placed between the decode/execute stage and the CP0 register file. It collects synchronous exception requests (syscall, break, teq) and an asynchronous external interrupt, and gates them against the CP0 status word. It then drives CP0's exception/eret strobes and the PC redirect as a fixed two-cycle sequence. It also tracks nesting depth so the 5-bit-per-level status stack never overflows.

## Interface
- EXC_VECTOR, 32'h0040_0004: handler entry address driven on redirect_pc for exceptions.
- MAX_DEPTH, 6: maximum nested exception levels (32-bit status / 5 bits per level).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inst_valid  in  1  current instruction flags and pc are valid this cycle.
- pc  in  32  address of current instruction.
- is_syscall / is_break / is_teq / is_eret  in  1 each  decoded instruction type; at most one set.
- teq_eq  in  1  teq operands equal (trap condition true).
- irq  in  1  external interrupt, asynchronous level.
- status  in  32  CP0 status word.
- epc  in  32  CP0 EPC (exc_addr).
- stall  out  1  hold PC, suppress register/memory writes of current instruction.
- exception  out  1  one-cycle strobe to CP0.
- cause  out  5  cause code to CP0: syscall 5'd8, break 5'd9, teq 5'd13, interrupt 5'd0.
- exc_pc  out  32  value CP0 writes to EPC.
- eret  out  1  one-cycle strobe to CP0 (status pop).
- redirect  out  1  load redirect_pc into PC this cycle.
- redirect_pc  out  32  new PC.
- depth  out  3  current nesting level.
- irq_pending  out  1  synchronized, latched interrupt awaiting service.

## Operation
- Enables: status[0] global IE; status[1] syscall, status[2] break, status[3] teq, status[4] interrupt. A source is takeable only if status[0] and its own bit are both 1, and depth < MAX_DEPTH.
- A masked syscall/break/teq is dropped: the instruction completes as a nop, with no stall.
- teq requests only when is_teq & teq_eq.
- irq passes through a 2-flop synchronizer. A rising level sets irq_pending. irq_pending clears only when the interrupt is taken. A masked interrupt stays pending.
- Priority among simultaneous requests (inst_valid=1, state IDLE): is_eret > synchronous exception > pending interrupt. The losing interrupt stays pending.
- FSM states: IDLE, TAKE, VEC, RET, RVEC.
  - IDLE: an accepted exception or interrupt moves to TAKE. An accepted eret (requires depth>0) moves to RET. eret with depth==0 is ignored and treated as a nop.
  - TAKE: exception=1; cause and exc_pc hold the values registered at acceptance (exc_pc = accepted pc); depth+1. Next state VEC.
  - VEC: redirect=1, redirect_pc=EXC_VECTOR. Next state IDLE.
  - RET: eret=1; depth−1. Next state RVEC.
  - RVEC: redirect=1, redirect_pc=epc, sampled in this cycle after CP0 has updated. Next state IDLE.
- stall = (IDLE & a request accepted this cycle) | TAKE | RET. This is the only combinational output.
- inst_valid is ignored outside IDLE. The core holds the instruction during stall.
- Handlers advance EPC past syscall/break/teq themselves; this block always records the faulting pc.

## Timing
- Reset values:
  - state IDLE, depth 0, irq_pending 0, synchronizer flops 0.
  - exception, eret, redirect 0; cause 0; exc_pc 0; redirect_pc 0; stall 0.
- Acceptance in cycle T gives the exception/eret strobe in T+1 and redirect in T+2. The next request is accepted no earlier than T+3.
- Interrupt latency is 2 cycles of synchronizer, then acceptance at the first IDLE cycle with inst_valid and enables set.
- depth saturates: no increment at MAX_DEPTH, which blocks acceptance anyway; no decrement at 0.
- rst mid-sequence returns to IDLE immediately and clears all outputs. A pending interrupt is lost.
- Strobes are exactly one cycle wide and never overlap one another. redirect is never high in the same cycle as exception or eret.

## Test plan
- status=0x1F, syscall at pc=0x00400100 → stall at T; exception=1 with cause=8 and exc_pc=0x00400100 at T+1; redirect=1 with redirect_pc=0x00400004 at T+2; depth=1.
- Following test 1, eret with epc=0x00400104 → eret=1 at T+1; redirect_pc=0x00400104 at T+2; depth=0.
- status=0x1D (syscall masked), syscall → no stall, no exception, depth unchanged.
- irq pulse with status[4]=0 → irq_pending=1 held. Then set status=0x1F → exception with cause=0 after the next accepted instruction; irq_pending clears.
- Break and a pending irq in the same cycle → cause=9 taken first. After that sequence completes and the handler re-enables status, the interrupt is taken (cause=0).
- Six nested syscalls, each with status=0x1F → depth=6; the seventh is dropped. Assert rst during a TAKE cycle → all outputs 0 and state IDLE in the same cycle.
